// File: rtl/display_pkg.sv
// display_pkg: shared state encoding and frame geometry for the display shifter
package display_pkg;
  typedef enum logic [2:0] {IDLE, ARM, LOW, HIGH, ADV, LATCH} state_t;
  localparam int SEGS_PER_DIGIT = 7;
  localparam int MAX_DIGITS = 4;
endpackage

// File: rtl/display_shifter_if.sv
// display_shifter_if: frame request, segment-decoder handshake and shift-register chain pins
interface display_shifter_if;
  logic start;
  logic [1:0] digit_count;
  logic led_data;
  logic [3:0] dp_mask;
  logic next_led;
  logic sr_clk;
  logic sr_data;
  logic sr_latch;
  logic busy;
  logic done;
  modport master (
    output start, digit_count, led_data, dp_mask,
    input next_led, sr_clk, sr_data, sr_latch, busy, done
  );
  modport slave (
    input start, digit_count, led_data, dp_mask,
    output next_led, sr_clk, sr_data, sr_latch, busy, done
  );
endinterface

// File: rtl/display_sr_phase.sv
// display_sr_phase: CLK_DIV-cycle phase counter flagging the first and last cycle of a phase
module display_sr_phase #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic first,
  output logic last
);
  logic [7:0] cnt;
  assign first = cnt == 8'd0;
  assign last = cnt == 8'(CLK_DIV - 1);
  // count while a timed phase runs, wrapping so back-to-back phases each get CLK_DIV cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= 8'd0;
    else cnt <= (run && !last) ? cnt + 8'd1 : 8'd0;
endmodule

// File: rtl/display_shifter.sv
// display_shifter: serialises 7-segment digit frames into a shift-register chain; DISPLAY_SHIFTER_DP_EN adds a DP bit per digit
module display_shifter
  import display_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input logic clk,
  input logic rst_n,
  display_shifter_if.slave bus
);
  localparam int DW = $clog2(MAX_DIGITS + 1);
  state_t state, state_nx, high_nx, adv_nx;
  logic [DW-1:0] n_dig, dig_cnt;
  logic [2:0] seg_cnt;
  logic sr_data_q, ph_run, ph_first, ph_last, seg_wrap, bit_val;
  assign ph_run = state inside {LOW, HIGH, LATCH};
  display_sr_phase #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk(clk),
    .rst_n(rst_n),
    .run(ph_run),
    .first(ph_first),
    .last(ph_last)
  );
`ifdef DISPLAY_SHIFTER_DP_EN
  assign seg_wrap = seg_cnt == 3'(SEGS_PER_DIGIT);
  assign bit_val = seg_wrap ? bus.dp_mask[dig_cnt[1:0]] : bus.led_data;
  assign high_nx = !seg_wrap ? ADV : (dig_cnt + DW'(1) == n_dig) ? LATCH : LOW;
  assign adv_nx = LOW;
`else
  logic dp_unused;
  assign dp_unused = ^bus.dp_mask;
  assign seg_wrap = seg_cnt == 3'(SEGS_PER_DIGIT - 1);
  assign bit_val = bus.led_data;
  assign high_nx = ADV;
  assign adv_nx = dig_cnt == n_dig ? LATCH : LOW;
`endif
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // frame capture, bit data and segment/digit position; counters advance on the last HIGH cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n_dig <= '0;
      dig_cnt <= '0;
      seg_cnt <= '0;
      sr_data_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        n_dig <= bus.digit_count == 2'd0 ? DW'(1) : DW'(bus.digit_count);
        dig_cnt <= '0;
        seg_cnt <= '0;
      end
      if (state == LOW && ph_first) sr_data_q <= bit_val;
      if (state == HIGH && ph_last) begin
        seg_cnt <= seg_wrap ? 3'd0 : seg_cnt + 3'd1;
        dig_cnt <= dig_cnt + DW'(seg_wrap);
      end
    end
  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = bus.start ? ARM : IDLE;
      ARM:   state_nx = LOW;
      LOW:   state_nx = ph_last ? HIGH : LOW;
      HIGH:  state_nx = ph_last ? high_nx : HIGH;
      ADV:   state_nx = adv_nx;
      LATCH: state_nx = ph_last ? IDLE : LATCH;
      default: state_nx = IDLE;
    endcase
  end
  assign bus.next_led = state inside {ARM, ADV};
  assign bus.sr_clk = state == HIGH;
  assign bus.sr_data = sr_data_q;
  assign bus.sr_latch = state == LATCH;
  assign bus.busy = state != IDLE;
  assign bus.done = state == LATCH && ph_last;
endmodule

// File: tb/tb_display_shifter.sv
// tb_display_shifter: randomized frames against a segment-stream model with a queue scoreboard
`timescale 1ns/1ps
module tb_display_shifter;
  localparam int CLK_DIV = 2;
  typedef struct {int nbits; int nled; int lat; int len;} frame_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  display_shifter_if bus();
  display_shifter #(.CLK_DIV(CLK_DIV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int failures = 0;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic seg_stream [32];
  int seg_total = 0;
  int dptr;
  int digs [4];
  logic exp_bits [$];
  frame_t exp_frames [$];
  int nbits, nled, nlat, nlen;
  logic prev_sr;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // segment decoder: armed by the first next_led, each later pulse moves to the next segment
  always @(posedge clk or negedge rst_n)
    if (!rst_n) dptr <= 0;
    else if (bus.start && !bus.busy) dptr <= 0;
    else if (bus.next_led) dptr <= dptr + 1;
  assign bus.led_data = (dptr >= 1 && dptr <= seg_total) ? seg_stream[dptr - 1] : 1'b0;

  // monitor: pops one expected bit per sr_clk rise and one frame record per done pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      nbits = 0; nled = 0; nlat = 0; nlen = 0; prev_sr = 1'b0;
    end else begin
      if (bus.busy) nlen++;
      if (bus.next_led) nled++;
      if (bus.sr_latch) nlat++;
      if (bus.sr_clk && !prev_sr) begin
        nbits++;
        if (exp_bits.size() == 0) begin
          checks++; failures++;
          $display("FAIL sr_bit unexpected rise, sr_data=%0d", bus.sr_data);
        end else check("sr_bit", int'(bus.sr_data), int'(exp_bits.pop_front()));
      end
      prev_sr = bus.sr_clk;
      if (bus.done) begin
        if (exp_frames.size() == 0) begin
          checks++; failures++;
          $display("FAIL frame unexpected done pulse");
        end else begin
          frame_t f;
          f = exp_frames.pop_front();
          check("frame_bits", nbits, f.nbits);
          check("frame_next_led", nled, f.nled);
          check("frame_latch_cycles", nlat, f.lat);
          check("frame_len_busy", nlen, f.len);
        end
        nbits = 0; nled = 0; nlat = 0; nlen = 0;
      end
    end
  end

  task automatic start_frame(input int dc, input logic [3:0] dpm);
    int n = dc == 0 ? 1 : dc;
    int nb = 0;
    seg_total = 7 * n;
    for (int k = 0; k < n; k++) begin
      for (int s = 0; s < 7; s++) begin
        seg_stream[k * 7 + s] = seg_tab[digs[k]][s];
        exp_bits.push_back(seg_tab[digs[k]][s]);
        nb++;
      end
`ifdef DISPLAY_SHIFTER_DP_EN
      exp_bits.push_back(dpm[k]);
      nb++;
`endif
    end
    exp_frames.push_back('{nb, 7 * n + 1, CLK_DIV, 1 + nb * 2 * CLK_DIV + 7 * n + CLK_DIV});
    bus.digit_count = dc[1:0];
    bus.dp_mask = dpm;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_bits.delete();
    exp_frames.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input bit start_on_done);
    int t = 0;
    while (!bus.done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.done) begin
      checks++; failures++;
      $display("FAIL done_timeout waited=%0d cycles, required done pulse", t);
      do_reset();
    end else if (start_on_done) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_after_start_with_done", int'(bus.busy), 0);
      repeat (3) @(negedge clk);
      check("start_with_done_not_queued", int'(bus.busy), 0);
    end else @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    bus.start = 1'b0;
    bus.digit_count = 2'd0;
    bus.dp_mask = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_state", int'({bus.next_led, bus.sr_clk, bus.sr_data, bus.sr_latch, bus.busy, bus.done}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    digs = '{7, 0, 0, 0}; start_frame(1, 4'b0000); wait_done(0);
    digs = '{5, 0, 0, 0}; start_frame(0, 4'b0001); wait_done(0);
    digs = '{3, 2, 1, 0}; start_frame(3, 4'b0101); wait_done(0);
    digs = '{4, 9, 0, 0}; start_frame(2, 4'b0010); wait_done(0);
    digs = '{8, 6, 0, 0}; start_frame(2, 4'b1111);
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.digit_count = 2'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(1);
    digs = '{1, 8, 0, 0}; start_frame(2, 4'b0011);
    t = 0;
    while (!bus.sr_clk && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("reached_high_phase", int'(bus.sr_clk), 1);
    #1 rst_n = 1'b0;
    #1 check("async_reset_outputs", int'({bus.next_led, bus.sr_clk, bus.sr_data, bus.sr_latch, bus.busy, bus.done}), 0);
    exp_bits.delete();
    exp_frames.delete();
    repeat (2) @(negedge clk);
    check("no_latch_in_reset", int'(bus.sr_latch), 0);
    rst_n = 1'b1;
    @(negedge clk);
    digs = '{0, 1, 2, 0}; start_frame(3, 4'b0110); wait_done(0);
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 4; k++) digs[k] = int'($urandom_range(9));
      start_frame(int'($urandom_range(3)), 4'($urandom));
      wait_done(r % 3 == 0);
    end
    check("scoreboard_drained", exp_bits.size() + exp_frames.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
